// File: rtl/exmem_stage_buf.sv
// exmem_stage_buf: EX/MEM stage register with valid/ready handshake, 2-entry skid, flush, forwarding tap and stall counter
module exmem_stage_buf #(
  parameter int DW  = 16,
  parameter int RAW = 4,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           reg_write_in,
  input  logic           call_in,
  input  logic           mem_to_reg_in,
  input  logic           reg_to_mem_in,
  input  logic [RAW-1:0] reg_rd_in,
  input  logic [DW-1:0]  alu_result_in,
  input  logic [DW-1:0]  save_word_data_in,
  input  logic           ret_future_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           reg_write_out,
  output logic           call_out,
  output logic           mem_to_reg_out,
  output logic           reg_to_mem_out,
  output logic [RAW-1:0] reg_rd_out,
  output logic [DW-1:0]  alu_result_out,
  output logic [DW-1:0]  save_word_data_out,
  output logic           ret_future_out,
  output logic           fwd_valid,
  output logic [RAW-1:0] fwd_rd,
  output logic [DW-1:0]  fwd_data,
  output logic [SCW-1:0] stall_count
);
  localparam int EW = 5 + RAW + 2 * DW;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [EW-1:0] main_q, skid_q, in_e;
  logic accept, consume, load_in, load_skid, skid_to_main;
  assign in_e = {reg_write_in, call_in, mem_to_reg_in, reg_to_mem_in, ret_future_in,
                 reg_rd_in, alu_result_in, save_word_data_in};
  assign out_valid = state != EMPTY;
  assign accept = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  // control bits are gated by valid; data fields simply hold
  assign {reg_write_out, call_out, mem_to_reg_out, reg_to_mem_out, ret_future_out} =
         {5{out_valid}} & main_q[EW-1 -: 5];
  assign reg_rd_out = main_q[2*DW +: RAW];
  assign alu_result_out = main_q[DW +: DW];
  assign save_word_data_out = main_q[DW-1:0];
  assign fwd_valid = out_valid && reg_write_out && !mem_to_reg_out;
  assign fwd_rd = reg_rd_out;
  assign fwd_data = alu_result_out;
  always_comb begin
    state_n = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    skid_to_main = 1'b0;
    if (flush) state_n = EMPTY;
    else case (state)
      EMPTY: begin
        state_n = accept ? ONE : EMPTY;
        load_in = accept;
      end
      ONE: begin
        state_n = (accept && !consume) ? TWO : (!accept && consume) ? EMPTY : ONE;
        load_in = accept && consume;
        load_skid = accept && !consume;
      end
      TWO: begin
        state_n = consume ? ONE : TWO;
        skid_to_main = consume;
      end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
      stall_count <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n != TWO;
      if (load_in) main_q <= in_e;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid) skid_q <= in_e;
      if (out_valid && !out_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_exmem_stage_buf.sv
// tb_exmem_stage_buf: directed and randomized checks of exmem_stage_buf against a FIFO reference model
module tb_exmem_stage_buf;
  typedef struct packed {
    logic rw, call, m2r, r2m, ret;
    logic [3:0] rd;
    logic [15:0] alu, swd;
  } ent_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  ent_t in_e = '0;
  logic in_ready, out_valid, reg_write_out, call_out, mem_to_reg_out, reg_to_mem_out, ret_future_out, fwd_valid;
  logic [3:0] reg_rd_out, fwd_rd, stall_count;
  logic [15:0] alu_result_out, save_word_data_out, fwd_data;
  int errors = 0, checks = 0;
  ent_t q[$];
  ent_t last = '0;
  int m_stall = 0;
  bit m_rdy = 1;

  exmem_stage_buf #(.DW(16), .RAW(4), .SCW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_in(in_e.rw), .call_in(in_e.call), .mem_to_reg_in(in_e.m2r), .reg_to_mem_in(in_e.r2m),
    .reg_rd_in(in_e.rd), .alu_result_in(in_e.alu), .save_word_data_in(in_e.swd), .ret_future_in(in_e.ret),
    .out_valid(out_valid), .out_ready(out_ready), .reg_write_out(reg_write_out), .call_out(call_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_to_mem_out(reg_to_mem_out), .reg_rd_out(reg_rd_out),
    .alu_result_out(alu_result_out), .save_word_data_out(save_word_data_out), .ret_future_out(ret_future_out),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // reference: a 2-deep FIFO whose ready is decided from the occupancy after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last = '0;
      m_stall = 0;
      m_rdy = 1;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < 15) m_stall++;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back(in_e);
      end
      if (q.size() > 0) last = q[0];
      m_rdy = q.size() < 2;
    end
  end

  task automatic do_reset();
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_e = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  function automatic ent_t mk(input logic rw, m2r, r2m, call, input logic [3:0] rd, input logic [15:0] alu, swd);
    ent_t e = '0;
    e.rw = rw; e.m2r = m2r; e.r2m = r2m; e.call = call; e.rd = rd; e.alu = alu; e.swd = swd;
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0h want 1", in_ready); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
    in_e = mk(1, 0, 1, 1, 4'd9, 16'hAAAA, 16'h5555); in_valid = 1;
    @(negedge clk);
    in_e.alu = 16'hBBBB;
    @(negedge clk);
    in_valid = 0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_fill_two: got %0h want 0", in_ready); end
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %0h want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %0h want 1", in_ready); end
    checks++; if ({reg_write_out, call_out, reg_to_mem_out, reg_rd_out, alu_result_out, save_word_data_out} !== '0)
      begin errors++; $display("FAIL arst_outs: got %0h want 0", {reg_write_out, call_out, reg_to_mem_out, reg_rd_out, alu_result_out, save_word_data_out}); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL arst_stall: got %0d want 0", stall_count); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_discard: got %0h want 0", out_valid); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1;
    in_e = mk(1, 0, 0, 0, 4'd3, 16'h1234, 16'h0001); in_valid = 1;
    @(negedge clk);
    in_e = mk(0, 0, 0, 0, 4'd5, 16'hBEEF, 16'h0002);
    checks++; if (out_valid !== 1'b1 || alu_result_out !== 16'h1234 || reg_rd_out !== 4'd3)
      begin errors++; $display("FAIL stream_a: got v=%0h rd=%0h alu=%0h want v=1 rd=3 alu=1234", out_valid, reg_rd_out, alu_result_out); end
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 4'd3 || fwd_data !== 16'h1234)
      begin errors++; $display("FAIL stream_fwd: got %0h/%0h/%0h want 1/3/1234", fwd_valid, fwd_rd, fwd_data); end
    @(negedge clk);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || alu_result_out !== 16'hBEEF || reg_rd_out !== 4'd5 || fwd_valid !== 1'b0)
      begin errors++; $display("FAIL stream_b: got v=%0h rd=%0h alu=%0h fwd=%0h want 1 5 beef 0", out_valid, reg_rd_out, alu_result_out, fwd_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || alu_result_out !== 16'hBEEF)
      begin errors++; $display("FAIL stream_drain: got v=%0h alu=%0h want 0 beef", out_valid, alu_result_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_e = mk(1, 0, 0, 0, 4'd1, 16'h00A1, 16'h0); in_valid = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || alu_result_out !== 16'h00A1)
      begin errors++; $display("FAIL bp_one: got rdy=%0h alu=%0h want 1 a1", in_ready, alu_result_out); end
    in_e = mk(1, 0, 0, 0, 4'd2, 16'h00B2, 16'h0);
    @(negedge clk);
    in_valid = 0;
    checks++; if (in_ready !== 1'b0 || alu_result_out !== 16'h00A1)
      begin errors++; $display("FAIL bp_two: got rdy=%0h alu=%0h want 0 a1", in_ready, alu_result_out); end
    repeat (3) @(negedge clk);
    checks++; if (stall_count !== 4'd4 || alu_result_out !== 16'h00A1)
      begin errors++; $display("FAIL bp_hold: got stall=%0d alu=%0h want 4 a1", stall_count, alu_result_out); end
    out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || alu_result_out !== 16'h00B2 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_b: got v=%0h alu=%0h rdy=%0h want 1 b2 1", out_valid, alu_result_out, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || stall_count !== 4'd4)
      begin errors++; $display("FAIL bp_done: got v=%0h stall=%0d want 0 4", out_valid, stall_count); end
  endtask

  task automatic test_flush();
    do_reset();
    in_e = mk(0, 0, 1, 1, 4'd4, 16'h0C01, 16'hD00D); in_valid = 1;
    @(negedge clk);
    in_e.alu = 16'h0C02;
    @(negedge clk);
    in_e.alu = 16'h0C03; flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;
    checks++; if (out_valid !== 1'b0 || reg_to_mem_out !== 1'b0 || call_out !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_two: got v=%0h sw=%0h call=%0h rdy=%0h want 0 0 0 1", out_valid, reg_to_mem_out, call_out, in_ready); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL flush_stall: got %0d want 2", stall_count); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_gone: got %0h want 0", out_valid); end
    in_e.alu = 16'h0C04; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_e.alu = 16'h0C05; flush = 1;
    @(negedge clk);
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_one: got v=%0h rdy=%0h want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_load();
    do_reset();
    out_ready = 1;
    in_e = mk(1, 1, 0, 0, 4'd7, 16'h4000, 16'h0); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    checks++; if (fwd_valid !== 1'b0 || reg_write_out !== 1'b1 || mem_to_reg_out !== 1'b1 || reg_rd_out !== 4'd7)
      begin errors++; $display("FAIL load_gate: got fwd=%0h rw=%0h m2r=%0h rd=%0h want 0 1 1 7", fwd_valid, reg_write_out, mem_to_reg_out, reg_rd_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_e = mk(0, 0, 0, 0, 4'd0, 16'h0, 16'h0); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    checks++; if (stall_count !== 4'd10) begin errors++; $display("FAIL sat_mid: got %0d want 10", stall_count); end
    repeat (10) @(negedge clk);
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_top: got %0d want 15", stall_count); end
  endtask

  task automatic test_random();
    ent_t f, exp_e, act_e;
    bit v;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      v = q.size() > 0;
      f = v ? q[0] : last;
      exp_e = f;
      if (!v) {exp_e.rw, exp_e.call, exp_e.m2r, exp_e.r2m, exp_e.ret} = '0;
      act_e = {reg_write_out, call_out, mem_to_reg_out, reg_to_mem_out, ret_future_out, reg_rd_out, alu_result_out, save_word_data_out};
      checks++; if (out_valid !== v || in_ready !== m_rdy)
        begin errors++; $display("FAIL rnd_hs[%0d]: got v=%0h rdy=%0h want v=%0h rdy=%0h", i, out_valid, in_ready, v, m_rdy); end
      checks++; if (act_e !== exp_e)
        begin errors++; $display("FAIL rnd_ent[%0d]: got %h want %h", i, act_e, exp_e); end
      checks++; if (fwd_valid !== (v && f.rw && !f.m2r) || fwd_rd !== f.rd || fwd_data !== f.alu)
        begin errors++; $display("FAIL rnd_fwd[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", i, fwd_valid, fwd_rd, fwd_data, v && f.rw && !f.m2r, f.rd, f.alu); end
      checks++; if (stall_count !== 4'(m_stall))
        begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_count, m_stall); end
      in_e = ent_t'({$urandom, $urandom});
      in_valid = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      if (i == 200) m_stall = m_stall;
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_load();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exmem_stage_buf.md
Name: exmem_stage_buf

Overview:
- Next-generation EX/MEM pipeline stage register for the WISC pipeline.
- Generalises the plain per-cycle EX/MEM latch in three ways:
  - parametrised data and register-address widths;
  - valid/ready handshake, so the memory unit can stall the stage;
  - a 2-entry skid buffer, so EX is never combinationally back-pressured.
- Adds a synchronous flush for branch/ret squash, a forwarding tap, and a saturating stall counter.
- Sits between the ALU/EX stage and the memory unit.

Parameters:
DW, 16, width of alu_result and save_word_data
RAW, 4, width of destination register address
SCW, 16, width of stall counter

Ports:
clk  in  1  clock
rst_n  in  1  reset
flush  in  1  squash all held entries this cycle
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage can accept (registered)
reg_write_in  in  1  RegWrite from EX
call_in  in  1  call (SP decrement)
mem_to_reg_in  in  1  LW
reg_to_mem_in  in  1  SW
reg_rd_in  in  RAW  destination register
alu_result_in  in  DW  ALU result / address
save_word_data_in  in  DW  store data
ret_future_in  in  1  future ret_wb
out_valid  out  1  memory unit has an instruction
out_ready  in  1  memory unit consumes this cycle
reg_write_out  out  1  qualified RegWrite
call_out  out  1  qualified call
mem_to_reg_out  out  1  qualified LW
reg_to_mem_out  out  1  qualified SW
reg_rd_out  out  RAW  destination register
alu_result_out  out  DW  ALU result
save_word_data_out  out  DW  store data
ret_future_out  out  1  qualified ret_wb
fwd_valid  out  1  forwardable ALU result present
fwd_rd  out  RAW  forwarding destination
fwd_data  out  DW  forwarding value
stall_count  out  SCW  cycles with out_valid && !out_ready, saturating

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - all outputs 0, except in_ready=1;
  - state EMPTY, skid register cleared;
  - reset mid-transfer discards both entries.
- Storage:
  - main register drives the *_out ports;
  - skid register holds one overflow entry;
  - occupancy states: EMPTY, ONE, TWO.
- Handshake:
  - accept = in_valid && in_ready;
  - consume = out_valid && out_ready;
  - in_ready = (state != TWO), from a flop, never combinational on out_ready;
  - out_valid = (state != EMPTY).
- Transitions (no flush):
  - EMPTY: accept -> ONE; accepted entry enters main, visible next cycle (latency 1).
  - ONE, accept && consume -> ONE; main loads new entry.
  - ONE, accept && !consume -> TWO; new entry enters skid.
  - ONE, !accept && consume -> EMPTY.
  - ONE, no event -> ONE, hold.
  - TWO, consume -> ONE; skid moves to main.
  - TWO, no consume -> TWO, hold. No accept is possible since in_ready=0.
- Ordering: strictly FIFO; an entry never overtakes another.
- Flush:
  - next state EMPTY;
  - any same-cycle in_valid is dropped;
  - in_ready=1 next cycle;
  - a consume in the flush cycle still completes, since the memory unit saw valid outputs.
- Qualification:
  - reg_write_out, call_out, mem_to_reg_out, reg_to_mem_out and ret_future_out are 0 whenever out_valid=0;
  - reg_rd_out, alu_result_out and save_word_data_out hold their last value when invalid.
- Forwarding tap:
  - fwd_valid = out_valid && reg_write_out && !mem_to_reg_out;
  - fwd_rd = reg_rd_out;
  - fwd_data = alu_result_out;
  - combinational from main only; the skid is not forwarded.
- stall_count:
  - increments each cycle out_valid && !out_ready;
  - saturates at 2^SCW-1;
  - cleared only by reset;
  - flush does not clear it.
- Widths: no arithmetic on data; all fields are copied bit-exact.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with state TWO -> immediately out_valid=0, in_ready=1, all *_out=0, stall_count=0.
- Streaming: out_ready=1; accept A (rd=3, alu=0x1234, reg_write=1) then B (rd=5, alu=0xBEEF) on consecutive cycles -> A on outputs cycle+1, B cycle+2; fwd_valid=1, fwd_rd=3, fwd_data=0x1234 for A.
- Back-pressure: out_ready=0; accept A, B -> state TWO, in_ready=0 next cycle, A held. Raise out_ready -> A, then B, each consumed once; stall_count equals the held cycles.
- Flush: in TWO with in_valid=1, assert flush -> next cycle out_valid=0, reg_to_mem_out=0, call_out=0, in_ready=1; the flushed and dropped entries never appear.
- Load gating: accept LW (mem_to_reg=1, reg_write=1, rd=7) -> fwd_valid=0 while reg_write_out=1, mem_to_reg_out=1.
- Saturation (SCW=4): hold out_valid with out_ready=0 for 20 cycles -> stall_count stops at 15.
